arc4_sched: RTL and testbench
=============================

# arc4_sched

Top-level sequencer for the ARC4 decrypt datapath. On one start handshake it runs the init, KSA and PRGA engines strictly in that order. It multiplexes the single shared S-memory write/address port to whichever engine owns the current phase, and reports completion plus a cycle count. It sits between the board top (switch key, ciphertext/plaintext memories) and the three engines, replacing ad-hoc chaining logic.

## Interface
Parameters:
- `CNT_W`, 32: width of the busy-cycle counter (saturating).

Ports:
- `clk` in 1: system clock (50 MHz board clock).
- `rst_n` in 1: reset, asynchronous, active-low.
- `en` in 1: start request; accepted only when `rdy`=1.
- `rdy` out 1: 1 = idle, can accept `en`.
- `phase` out 2: 0 idle, 1 init, 2 ksa, 3 prga.
- `cycles` out CNT_W: cycles spent busy in the last or current run.
- `init_en` out 1, `init_rdy` in 1: init engine handshake.
- `ksa_en` out 1, `ksa_rdy` in 1: KSA engine handshake.
- `prga_en` out 1, `prga_rdy` in 1: PRGA engine handshake.
- `init_addr`/`ksa_addr`/`prga_addr` in 8: engine S address.
- `init_wrdata`/`ksa_wrdata`/`prga_wrdata` in 8: engine S write data.
- `init_wren`/`ksa_wren`/`prga_wren` in 1: engine S write enable.
- `s_addr` out 8, `s_wrdata` out 8, `s_wren` out 1: to S memory. S read data fans out to all engines outside this block.

## Operation
- FSM states: IDLE, INIT_GO, INIT_GRD, INIT_WT, KSA_GO, KSA_GRD, KSA_WT, PRGA_GO, PRGA_GRD, PRGA_WT.
- IDLE: `rdy`=1. On `en`=1, go to INIT_GO, clear `cycles` to 0. An `en` arriving while not idle is ignored, with no queueing.
- X_GO: wait until `x_rdy`=1. In the cycle that `x_rdy`=1, assert `x_en`=1 for exactly that cycle and go to X_GRD.
- X_GRD: one-cycle guard; `x_rdy` is ignored because the engine drops it the cycle after `en`. Go to X_WT.
- X_WT: when `x_rdy`=1, go to the next phase's GO state. From PRGA_WT, go to IDLE.
- Ownership: `phase` is 1 in INIT_*, 2 in KSA_*, 3 in PRGA_*, and 0 in IDLE. The S port is a combinational mux on registered `phase`:
  - The owner's addr/wrdata/wren pass straight through.
  - When `phase`=0: `s_addr`=0, `s_wrdata`=0, `s_wren`=0.
  - Non-owner write enables are ignored. This is the only arbitration: no overlap is possible, by construction.
- `cycles`: increments by 1 in every non-IDLE cycle and saturates at all-ones. It holds its value in IDLE until the next accepted start.
- At most one `x_en` is high in any cycle. Each engine gets exactly one `en` pulse per run.

## Timing
- Reset values: state IDLE, `rdy`=1, `phase`=0, `cycles`=0, all `x_en`=0, `s_wren`=0, `s_addr`=0, `s_wrdata`=0.
- Reset mid-run: immediately return to IDLE with the values above. Engines are reset by the same `rst_n`.
- `en` sampled at edge t: `rdy`=0 and `phase`=1 from t+1. `init_en` is high in cycle t+1 if `init_rdy`=1.
- Engine reporting rdy at edge u in X_WT: the next engine's `en` is asserted at the earliest in cycle u+1. After PRGA, `rdy`=1 and `phase`=0 from u+1.
- Minimum run with engines always ready after the guard: 9 busy cycles, so `cycles`=9.
- Mux path: combinational. `s_*` is valid in the same cycle as the engine's outputs, with no added latency.
- `x_en` is driven from registered state AND `x_rdy`. There is no combinational path from `en` to any output.

## Structure
- Shared package `arc4_pkg`:
  - state enum `sched_state_t`;
  - phase constants `PH_IDLE`=0, `PH_INIT`=1, `PH_KSA`=2, `PH_PRGA`=3;
  - `S_AW`=8, `S_DW`=8.
- One natural sub-module: `s_port_mux` (3:1 owner mux with the idle-zero default).
- FSM and counter stay in `arc4_sched`.

## Test plan
- **Basic run:** reset, then `en`=1 for one cycle with engine models whose rdy returns 3 cycles after `en` → `phase` steps 1→2→3→0. Each `x_en` is a single pulse, in order. `rdy` returns to 1. `cycles`=3×(1+1+3)=15.
- **Late engine rdy:** hold `ksa_rdy`=0 for 10 cycles on entry to KSA_GO → `ksa_en` is not asserted until `ksa_rdy`=1, then pulses once. `cycles` includes the wait.
- **Mux ownership:** during KSA, drive `ksa_addr`=8'hA5, `ksa_wrdata`=8'h3C, `ksa_wren`=1, and `init_wren`=`prga_wren`=1 → `s_addr`=A5, `s_wrdata`=3C, `s_wren`=1. In IDLE the same inputs give all zeros on `s_*`.
- **Busy start ignored:** pulse `en` during PRGA_WT → no second init pulse. After completion, exactly one run has occurred.
- **Reset mid-run:** drop `rst_n` during KSA_WT → asynchronous return to IDLE, `rdy`=1, `phase`=0, `cycles`=0, `s_wren`=0. A later `en` starts again from init.
- **Saturation:** with `CNT_W`=4 and engines stalled for 30 cycles → `cycles` stops at 4'hF.

Source files
------------

// File: rtl/arc4_pkg.sv
// Shared definitions for the ARC4 decrypt datapath: scheduler states, phase codes
// and S-memory port widths.
package arc4_pkg;

   localparam int S_AW = 8;
   localparam int S_DW = 8;

   localparam logic [1:0] PH_IDLE = 2'd0;
   localparam logic [1:0] PH_INIT = 2'd1;
   localparam logic [1:0] PH_KSA  = 2'd2;
   localparam logic [1:0] PH_PRGA = 2'd3;

   typedef enum logic [3:0] {
      IDLE     = 4'd0,
      INIT_GO  = 4'd1,
      INIT_GRD = 4'd2,
      INIT_WT  = 4'd3,
      KSA_GO   = 4'd4,
      KSA_GRD  = 4'd5,
      KSA_WT   = 4'd6,
      PRGA_GO  = 4'd7,
      PRGA_GRD = 4'd8,
      PRGA_WT  = 4'd9
   } sched_state_t;

   // Which engine owns the S port while the scheduler sits in a given state.
   function automatic logic [1:0] state_phase(input sched_state_t s);
      logic [1:0] ph;
      case (s)
         INIT_GO, INIT_GRD, INIT_WT: ph = PH_INIT;
         KSA_GO,  KSA_GRD,  KSA_WT:  ph = PH_KSA;
         PRGA_GO, PRGA_GRD, PRGA_WT: ph = PH_PRGA;
         default:                    ph = PH_IDLE;
      endcase
      return ph;
   endfunction

endpackage

// File: rtl/arc4_sched_s_port_mux.sv
// 3:1 S-memory port mux selected by the scheduler phase; drives all zeros when idle.
module s_port_mux
   import arc4_pkg::*;
(
   input  logic [1:0]      phase,
   input  logic [S_AW-1:0] init_addr,
   input  logic [S_DW-1:0] init_wrdata,
   input  logic            init_wren,
   input  logic [S_AW-1:0] ksa_addr,
   input  logic [S_DW-1:0] ksa_wrdata,
   input  logic            ksa_wren,
   input  logic [S_AW-1:0] prga_addr,
   input  logic [S_DW-1:0] prga_wrdata,
   input  logic            prga_wren,
   output logic [S_AW-1:0] s_addr,
   output logic [S_DW-1:0] s_wrdata,
   output logic            s_wren
);

   always_comb begin
      s_addr   = '0;
      s_wrdata = '0;
      s_wren   = 1'b0;
      case (phase)
         PH_INIT: begin
            s_addr   = init_addr;
            s_wrdata = init_wrdata;
            s_wren   = init_wren;
         end
         PH_KSA: begin
            s_addr   = ksa_addr;
            s_wrdata = ksa_wrdata;
            s_wren   = ksa_wren;
         end
         PH_PRGA: begin
            s_addr   = prga_addr;
            s_wrdata = prga_wrdata;
            s_wren   = prga_wren;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/arc4_sched.sv
// ARC4 top-level sequencer: runs init, KSA and PRGA in order on one start handshake,
// owns the shared S port and counts busy cycles.
module arc4_sched
   import arc4_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   output logic             rdy,
   output logic [1:0]       phase,
   output logic [CNT_W-1:0] cycles,
   output logic             init_en,
   input  logic             init_rdy,
   output logic             ksa_en,
   input  logic             ksa_rdy,
   output logic             prga_en,
   input  logic             prga_rdy,
   input  logic [S_AW-1:0]  init_addr,
   input  logic [S_DW-1:0]  init_wrdata,
   input  logic             init_wren,
   input  logic [S_AW-1:0]  ksa_addr,
   input  logic [S_DW-1:0]  ksa_wrdata,
   input  logic             ksa_wren,
   input  logic [S_AW-1:0]  prga_addr,
   input  logic [S_DW-1:0]  prga_wrdata,
   input  logic             prga_wren,
   output logic [S_AW-1:0]  s_addr,
   output logic [S_DW-1:0]  s_wrdata,
   output logic             s_wren
);

   // Handshake: an engine is started by a one-cycle x_en while it reports x_rdy=1;
   // it drops x_rdy the cycle after x_en and raises it again when its work is done.
   sched_state_t     state_q, state_d;
   logic [1:0]       phase_q, phase_d;
   logic [CNT_W-1:0] cycles_q, cycles_d;

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:     if (en)       state_d = INIT_GO;
         INIT_GO:  if (init_rdy) state_d = INIT_GRD;
         INIT_GRD:               state_d = INIT_WT;
         INIT_WT:  if (init_rdy) state_d = KSA_GO;
         KSA_GO:   if (ksa_rdy)  state_d = KSA_GRD;
         KSA_GRD:                state_d = KSA_WT;
         KSA_WT:   if (ksa_rdy)  state_d = PRGA_GO;
         PRGA_GO:  if (prga_rdy) state_d = PRGA_GRD;
         PRGA_GRD:               state_d = PRGA_WT;
         PRGA_WT:  if (prga_rdy) state_d = IDLE;
         default:                state_d = IDLE;
      endcase
   end

   assign phase_d = state_phase(state_d);

   // The count restarts on an accepted start and otherwise holds across idle.
   always_comb begin
      cycles_d = cycles_q;
      if (state_q == IDLE) begin
         if (en) cycles_d = '0;
      end else if (cycles_q != '1) begin
         cycles_d = cycles_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         phase_q  <= PH_IDLE;
         cycles_q <= '0;
      end else begin
         state_q  <= state_d;
         phase_q  <= phase_d;
         cycles_q <= cycles_d;
      end
   end

   assign rdy     = (state_q == IDLE);
   assign phase   = phase_q;
   assign cycles  = cycles_q;
   assign init_en = (state_q == INIT_GO) && init_rdy;
   assign ksa_en  = (state_q == KSA_GO)  && ksa_rdy;
   assign prga_en = (state_q == PRGA_GO) && prga_rdy;

   s_port_mux u_mux (
      .phase       (phase_q),
      .init_addr   (init_addr),
      .init_wrdata (init_wrdata),
      .init_wren   (init_wren),
      .ksa_addr    (ksa_addr),
      .ksa_wrdata  (ksa_wrdata),
      .ksa_wren    (ksa_wren),
      .prga_addr   (prga_addr),
      .prga_wrdata (prga_wrdata),
      .prga_wren   (prga_wren),
      .s_addr      (s_addr),
      .s_wrdata    (s_wrdata),
      .s_wren      (s_wren)
   );

endmodule

// File: tb/tb_arc4_sched.sv
// Bench for arc4_sched: engine models with programmable latency, an en-pulse
// scoreboard and per-scenario tasks; a 4-bit counter instance covers saturation.
module tb_arc4_sched;

   logic        clk;
   logic        rst_n;
   logic        en;
   logic        rdy;
   logic [1:0]  phase;
   logic [31:0] cycles;
   logic        init_en, ksa_en, prga_en;
   logic        init_rdy, ksa_rdy, prga_rdy;
   logic [7:0]  init_addr, ksa_addr, prga_addr;
   logic [7:0]  init_wrdata, ksa_wrdata, prga_wrdata;
   logic        init_wren, ksa_wren, prga_wren;
   logic [7:0]  s_addr, s_wrdata;
   logic        s_wren;

   logic        en2, init_rdy2, ksa_rdy2, prga_rdy2;
   logic        rdy2, init_en2, ksa_en2, prga_en2, s_wren2;
   logic [1:0]  phase2;
   logic [3:0]  cycles2;
   logic [7:0]  s_addr2, s_wrdata2;

   logic [7:0]  lat;
   logic        hold_init, hold_ksa, hold_prga;
   logic [7:0]  init_busy, ksa_busy, prga_busy;

   int chk_cnt;
   int pass_cnt;
   logic [1:0]  exp_q[$];
   logic [31:0] cyc_q[$];

   arc4_sched u_dut (
      .clk(clk), .rst_n(rst_n), .en(en), .rdy(rdy), .phase(phase), .cycles(cycles),
      .init_en(init_en), .init_rdy(init_rdy), .ksa_en(ksa_en), .ksa_rdy(ksa_rdy),
      .prga_en(prga_en), .prga_rdy(prga_rdy),
      .init_addr(init_addr), .init_wrdata(init_wrdata), .init_wren(init_wren),
      .ksa_addr(ksa_addr), .ksa_wrdata(ksa_wrdata), .ksa_wren(ksa_wren),
      .prga_addr(prga_addr), .prga_wrdata(prga_wrdata), .prga_wren(prga_wren),
      .s_addr(s_addr), .s_wrdata(s_wrdata), .s_wren(s_wren)
   );

   arc4_sched #(.CNT_W(4)) u_sat (
      .clk(clk), .rst_n(rst_n), .en(en2), .rdy(rdy2), .phase(phase2), .cycles(cycles2),
      .init_en(init_en2), .init_rdy(init_rdy2), .ksa_en(ksa_en2), .ksa_rdy(ksa_rdy2),
      .prga_en(prga_en2), .prga_rdy(prga_rdy2),
      .init_addr(8'h00), .init_wrdata(8'h00), .init_wren(1'b0),
      .ksa_addr(8'h00), .ksa_wrdata(8'h00), .ksa_wren(1'b0),
      .prga_addr(8'h00), .prga_wrdata(8'h00), .prga_wren(1'b0),
      .s_addr(s_addr2), .s_wrdata(s_wrdata2), .s_wren(s_wren2)
   );

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- engine models ----------------
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         init_busy <= 8'd0;
         ksa_busy  <= 8'd0;
         prga_busy <= 8'd0;
      end else begin
         if (init_en) init_busy <= lat; else if (init_busy != 0) init_busy <= init_busy - 8'd1;
         if (ksa_en)  ksa_busy  <= lat; else if (ksa_busy  != 0) ksa_busy  <= ksa_busy  - 8'd1;
         if (prga_en) prga_busy <= lat; else if (prga_busy != 0) prga_busy <= prga_busy - 8'd1;
      end
   end

   assign init_rdy = (init_busy == 8'd0) && !hold_init;
   assign ksa_rdy  = (ksa_busy  == 8'd0) && !hold_ksa;
   assign prga_rdy = (prga_busy == 8'd0) && !hold_prga;

   // ---------------- en-pulse scoreboard ----------------
   always @(negedge clk) begin
      int n;
      logic [1:0] code;
      logic [1:0] want;
      if (rst_n) begin
         n = int'(init_en) + int'(ksa_en) + int'(prga_en);
         if (n > 0) begin
            code = init_en ? 2'd1 : (ksa_en ? 2'd2 : 2'd3);
            chk_cnt++;
            if (n > 1) begin
               $display("FAIL multi_en: %0d engine enables high at once, want 1", n);
            end else if (exp_q.size() == 0) begin
               $display("FAIL unexpected_en: got en for phase %0d, want none", code);
            end else begin
               want = exp_q.pop_front();
               if (code !== want || phase !== want)
                  $display("FAIL en_order: got en %0d in phase %0d, want %0d", code, phase, want);
               else
                  pass_cnt++;
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic start_run(input logic [31:0] exp_cycles, input bit push_cyc);
      @(posedge clk); #1;
      en = 1'b1;
      exp_q.push_back(2'd1);
      exp_q.push_back(2'd2);
      exp_q.push_back(2'd3);
      if (push_cyc) cyc_q.push_back(exp_cycles);
      @(posedge clk); #1;
      en = 1'b0;
   endtask

   task automatic wait_idle(input int budget, input string name);
      logic [1:0] last;
      logic [1:0] nxt;
      logic [31:0] want;
      int bad;
      bit done;
      last = phase;
      bad  = 0;
      done = 1'b0;
      for (int i = 0; i < budget && !done; i++) begin
         @(negedge clk);
         if (phase !== last) begin
            nxt = last + 2'd1;
            if (phase !== nxt) bad++;
            last = phase;
         end
         if (rdy === 1'b1) done = 1'b1;
      end
      chk_cnt++;
      if (!done) $display("FAIL %s_timeout: rdy still %0b after %0d cycles, want 1", name, rdy, budget);
      else pass_cnt++;
      chk_cnt++;
      if (bad != 0 || phase !== 2'd0)
         $display("FAIL %s_phase_seq: %0d bad steps, final phase %0d, want 0 bad and 0", name, bad, phase);
      else pass_cnt++;
      if (cyc_q.size() > 0) begin
         want = cyc_q.pop_front();
         chk_cnt++;
         if (cycles !== want) $display("FAIL %s_cycles: got %0d want %0d", name, cycles, want);
         else pass_cnt++;
      end
      chk_cnt++;
      if (exp_q.size() != 0) $display("FAIL %s_missing_en: %0d enables not seen, want 0", name, exp_q.size());
      else pass_cnt++;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk_cnt++;
      if (rdy !== 1'b1 || phase !== 2'd0 || cycles !== 32'd0)
         $display("FAIL reset_status: rdy=%0b phase=%0d cycles=%0d want 1 0 0", rdy, phase, cycles);
      else pass_cnt++;
      chk_cnt++;
      if (init_en !== 1'b0 || ksa_en !== 1'b0 || prga_en !== 1'b0)
         $display("FAIL reset_en: %0b%0b%0b want 000", init_en, ksa_en, prga_en);
      else pass_cnt++;
      chk_cnt++;
      if (s_addr !== 8'h00 || s_wrdata !== 8'h00 || s_wren !== 1'b0)
         $display("FAIL reset_s_port: %h %h %0b want 00 00 0", s_addr, s_wrdata, s_wren);
      else pass_cnt++;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk_cnt++;
      if (rdy !== 1'b1 || phase !== 2'd0)
         $display("FAIL reset_release: rdy=%0b phase=%0d want 1 0", rdy, phase);
      else pass_cnt++;
   endtask

   task automatic test_basic();
      lat = 8'd3;
      start_run(32'd15, 1'b1);
      @(negedge clk);
      chk_cnt++;
      if (rdy !== 1'b0 || phase !== 2'd1 || init_en !== 1'b1)
         $display("FAIL basic_start: rdy=%0b phase=%0d init_en=%0b want 0 1 1", rdy, phase, init_en);
      else pass_cnt++;
      wait_idle(200, "basic");
   endtask

   task automatic test_late_rdy();
      int bad;
      bit found;
      lat = 8'd3;
      hold_ksa = 1'b1;
      start_run(32'd25, 1'b1);
      found = 1'b0;
      for (int i = 0; i < 50 && !found; i++) begin
         @(negedge clk);
         if (phase === 2'd2) found = 1'b1;
      end
      chk_cnt++;
      if (!found) $display("FAIL late_reach_ksa: phase %0d, want 2", phase);
      else pass_cnt++;
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         if (ksa_en !== 1'b0) bad++;
         @(posedge clk); #1;
         if (i == 9) hold_ksa = 1'b0;
         @(negedge clk);
      end
      chk_cnt++;
      if (bad != 0) $display("FAIL late_early_en: ksa_en high in %0d stalled cycles, want 0", bad);
      else pass_cnt++;
      chk_cnt++;
      if (ksa_en !== 1'b1) $display("FAIL late_en_release: ksa_en=%0b want 1", ksa_en);
      else pass_cnt++;
      wait_idle(200, "late");
   endtask

   task automatic test_mux();
      bit found;
      lat = 8'd3;
      hold_ksa = 1'b1;
      init_addr = 8'h11; init_wrdata = 8'h22; init_wren = 1'b1;
      ksa_addr  = 8'hA5; ksa_wrdata  = 8'h3C; ksa_wren  = 1'b1;
      prga_addr = 8'h77; prga_wrdata = 8'h88; prga_wren = 1'b1;
      start_run(32'd0, 1'b0);
      @(negedge clk);
      chk_cnt++;
      if (s_addr !== 8'h11 || s_wrdata !== 8'h22 || s_wren !== 1'b1)
         $display("FAIL mux_init: %h %h %0b want 11 22 1", s_addr, s_wrdata, s_wren);
      else pass_cnt++;
      found = 1'b0;
      for (int i = 0; i < 50 && !found; i++) begin
         @(negedge clk);
         if (phase === 2'd2) found = 1'b1;
      end
      chk_cnt++;
      if (!found || s_addr !== 8'hA5 || s_wrdata !== 8'h3C || s_wren !== 1'b1)
         $display("FAIL mux_ksa: phase %0d %h %h %0b want 2 a5 3c 1", phase, s_addr, s_wrdata, s_wren);
      else pass_cnt++;
      @(posedge clk); #1;
      ksa_wren = 1'b0;
      @(negedge clk);
      chk_cnt++;
      if (s_wren !== 1'b0) $display("FAIL mux_nonowner_wren: s_wren=%0b want 0", s_wren);
      else pass_cnt++;
      @(posedge clk); #1;
      ksa_wren = 1'b1;
      hold_ksa = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 50 && !found; i++) begin
         @(negedge clk);
         if (phase === 2'd3) found = 1'b1;
      end
      chk_cnt++;
      if (!found || s_addr !== 8'h77 || s_wrdata !== 8'h88)
         $display("FAIL mux_prga: phase %0d %h %h want 3 77 88", phase, s_addr, s_wrdata);
      else pass_cnt++;
      wait_idle(200, "mux");
      @(negedge clk);
      chk_cnt++;
      if (s_addr !== 8'h00 || s_wrdata !== 8'h00 || s_wren !== 1'b0)
         $display("FAIL mux_idle: %h %h %0b want 00 00 0", s_addr, s_wrdata, s_wren);
      else pass_cnt++;
      init_wren = 1'b0; ksa_wren = 1'b0; prga_wren = 1'b0;
   endtask

   task automatic test_busy_start();
      bit found;
      lat = 8'd3;
      start_run(32'd15, 1'b1);
      found = 1'b0;
      for (int i = 0; i < 50 && !found; i++) begin
         @(negedge clk);
         if (prga_en === 1'b1) found = 1'b1;
      end
      chk_cnt++;
      if (!found) $display("FAIL busy_reach_prga: prga_en never seen, want 1");
      else pass_cnt++;
      @(posedge clk); #1;
      @(posedge clk); #1;
      en = 1'b1;
      @(posedge clk); #1;
      en = 1'b0;
      wait_idle(200, "busy");
      repeat (5) @(negedge clk);
      chk_cnt++;
      if (rdy !== 1'b1 || phase !== 2'd0 || cycles !== 32'd15)
         $display("FAIL busy_after: rdy=%0b phase=%0d cycles=%0d want 1 0 15", rdy, phase, cycles);
      else pass_cnt++;
   endtask

   task automatic test_reset_mid();
      bit found;
      lat = 8'd3;
      ksa_wren = 1'b1;
      start_run(32'd0, 1'b0);
      found = 1'b0;
      for (int i = 0; i < 50 && !found; i++) begin
         @(negedge clk);
         if (ksa_en === 1'b1) found = 1'b1;
      end
      @(posedge clk);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk_cnt++;
      if (!found || rdy !== 1'b1 || phase !== 2'd0 || cycles !== 32'd0 || s_wren !== 1'b0)
         $display("FAIL rstmid_state: seen=%0b rdy=%0b phase=%0d cycles=%0d s_wren=%0b want 1 1 0 0 0",
                  found, rdy, phase, cycles, s_wren);
      else pass_cnt++;
      exp_q.delete();
      ksa_wren = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      start_run(32'd15, 1'b1);
      wait_idle(200, "rstmid_restart");
   endtask

   task automatic test_saturation();
      bit done;
      init_rdy2 = 1'b0; ksa_rdy2 = 1'b0; prga_rdy2 = 1'b0;
      @(posedge clk); #1;
      en2 = 1'b1;
      @(posedge clk); #1;
      en2 = 1'b0;
      @(negedge clk);
      chk_cnt++;
      if (cycles2 !== 4'd0 || phase2 !== 2'd1) $display("FAIL sat_start: cycles=%0d phase=%0d want 0 1", cycles2, phase2);
      else pass_cnt++;
      repeat (5) @(negedge clk);
      chk_cnt++;
      if (cycles2 !== 4'd5) $display("FAIL sat_count: cycles=%0d want 5", cycles2);
      else pass_cnt++;
      repeat (25) @(negedge clk);
      chk_cnt++;
      if (cycles2 !== 4'hF || phase2 !== 2'd1) $display("FAIL sat_stop: cycles=%0h phase=%0d want f 1", cycles2, phase2);
      else pass_cnt++;
      @(posedge clk); #1;
      init_rdy2 = 1'b1; ksa_rdy2 = 1'b1; prga_rdy2 = 1'b1;
      done = 1'b0;
      for (int i = 0; i < 30 && !done; i++) begin
         @(negedge clk);
         if (rdy2 === 1'b1) done = 1'b1;
      end
      chk_cnt++;
      if (!done || cycles2 !== 4'hF) $display("FAIL sat_end: rdy=%0b cycles=%0h want 1 f", rdy2, cycles2);
      else pass_cnt++;
   endtask

   initial begin
      chk_cnt = 0; pass_cnt = 0;
      rst_n = 1'b0; en = 1'b0; en2 = 1'b0;
      init_rdy2 = 1'b1; ksa_rdy2 = 1'b1; prga_rdy2 = 1'b1;
      lat = 8'd3;
      hold_init = 1'b0; hold_ksa = 1'b0; hold_prga = 1'b0;
      init_addr = 8'h00; init_wrdata = 8'h00; init_wren = 1'b0;
      ksa_addr  = 8'h00; ksa_wrdata  = 8'h00; ksa_wren  = 1'b0;
      prga_addr = 8'h00; prga_wrdata = 8'h00; prga_wren = 1'b0;
      test_reset();
      test_basic();
      test_late_rdy();
      test_mux();
      test_busy_start();
      test_reset_mid();
      test_saturation();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
